mc_controller: RTL
==================

# mc_controller

Multicycle MIPS control unit that sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback cycles. It replaces the single-cycle main decoder with a Moore FSM while keeping ALU control decoding in the existing `aludec`. It sits beside the multicycle datapath: it takes `op`/`funct`/`zero` and returns per-cycle enables and mux selects.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `op` input 6: instruction[31:26] from the instruction register; stable outside FETCH.
- `funct` input 6: instruction[5:0] from the instruction register.
- `zero` input 1: ALU zero flag, same cycle.
- `pcen` output 1: PC write enable.
- `iord` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `irwrite` output 1: instruction register load.
- `memwrite` output 1: memory write strobe.
- `memtoreg` output 1: register write-data select, 1 = data register.
- `regdst` output 1: destination select, 1 = rd, 0 = rt.
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: ALU A select, 0 = PC, 1 = rs.
- `alusrcb` output 2: ALU B select, 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- `pcsrc` output 2: next-PC select, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `zeroext` output 1: zero-extend immediate for andi/ori.
- `alucont` output 3: ALU function, 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `instr_done` output 1: one-cycle pulse in the final state of each instruction.

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- aluop (u3): 000 add, 001 sub, 010 use funct, 011 and, 100 or. `aludec` maps aluop/funct to `alucont`.
- All outputs are Moore outputs of the state. The one exception is `pcen`.
- Unlisted outputs in each state are 0; unlisted selects are don't-care and driven to 0.
- FETCH: iord 0, alusrca 0, alusrcb 01, aluop add, pcsrc 00, irwrite 1, pcen 1. Next state: DECODE.
- DECODE: alusrca 0, alusrcb 11, aluop add, computing the branch target into ALUOut. Next state by op:
  - lw/sw → MEMADR
  - R → EXECUTE
  - beq/bne → BRANCH
  - addi/andi/ori → IMMEX
  - j → JUMP
  - any other op → FETCH, with instr_done 1 (treated as NOP).
- MEMADR: alusrca 1, alusrcb 10, aluop add. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: iord 1. Next: MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1, instr_done 1. Next: FETCH.
- MEMWR: iord 1, memwrite 1, instr_done 1. Next: FETCH.
- EXECUTE: alusrca 1, alusrcb 00, aluop funct. Next: ALUWB.
- ALUWB: regdst 1, memtoreg 0, regwrite 1, instr_done 1. Next: FETCH.
- BRANCH: alusrca 1, alusrcb 00, aluop sub, pcsrc 01, instr_done 1.
  - pcen = (beq & zero) | (bne & ~zero).
  - Next: FETCH.
- IMMEX: alusrca 1, alusrcb 10. aluop: add for addi, and for andi, or for ori. zeroext 1 for andi/ori. Next: IMMWB.
- IMMWB: regdst 0, memtoreg 0, regwrite 1, instr_done 1. zeroext follows op. Next: FETCH.
- JUMP: pcsrc 10, pcen 1, instr_done 1. Next: FETCH.

## Timing
- State register updates on rising `clk`. Outputs are valid combinationally within the same cycle as the state. `pcen` in BRANCH also depends combinationally on `zero`.
- Reset: state ← FETCH at the next edge. While `reset` is high, pcen, irwrite, memwrite, regwrite and instr_done are forced to 0. Selects may follow FETCH.
- Reset asserted mid-instruction aborts it. No write occurs in that cycle, and the first cycle after deassertion is FETCH.
- Cycles per instruction: lw 5; sw, R, addi, andi, ori 4; beq, bne, j 3; unknown op 2.
- instr_done is high exactly 1 cycle per instruction. It is never high in two consecutive cycles.

## Structure
- A shared package (next to `common.svh`) holds:
  - the state enum, 4-bit encoded
  - the opcode constants
  - the aluop constants
  - the alusrcb and pcsrc encodings.
- Sub-modules: a new `mc_fsm` holds the state register, next-state logic and output decode. The existing `aludec` is instantiated unchanged. `mc_controller` only ties them together and applies reset gating.

## Test plan
- Reset held 3 cycles with op = lw → all enables 0. First post-reset cycle is FETCH: irwrite 1, pcen 1, alusrcb 01, alucont 010.
- lw → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMRD has iord 1. MEMWB has regwrite 1, memtoreg 1, regdst 0, instr_done 1.
- R-type with funct 101010 (slt) → EXECUTE has alucont 111, alusrcb 00. ALUWB has regdst 1, regwrite 1. Total 4 cycles.
- Branches in the BRANCH state:
  - beq with zero 1 → pcen 1, pcsrc 01, alucont 110.
  - beq with zero 0 → pcen 0.
  - bne with zero 0 → pcen 1.
  - bne with zero 1 → pcen 0.
- ori → IMMEX has alucont 001, zeroext 1, alusrcb 10. IMMWB has regwrite 1, regdst 0.
- j → JUMP has pcsrc 10, pcen 1. Illegal op 111111 → DECODE goes straight to FETCH with instr_done 1. Reset asserted during MEMWR → memwrite 0 that cycle, FETCH next.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: state, opcode, aluop and mux-select encodings for the multicycle control unit
package mc_controller_pkg;
    typedef logic [3:0] state_t;
    localparam state_t s_fetch   = 4'd0;
    localparam state_t s_decode  = 4'd1;
    localparam state_t s_memadr  = 4'd2;
    localparam state_t s_memrd   = 4'd3;
    localparam state_t s_memwb   = 4'd4;
    localparam state_t s_memwr   = 4'd5;
    localparam state_t s_execute = 4'd6;
    localparam state_t s_aluwb   = 4'd7;
    localparam state_t s_branch  = 4'd8;
    localparam state_t s_immex   = 4'd9;
    localparam state_t s_immwb   = 4'd10;
    localparam state_t s_jump    = 4'd11;
    localparam logic [5:0] op_r    = 6'b000000;
    localparam logic [5:0] op_lw   = 6'b100011;
    localparam logic [5:0] op_sw   = 6'b101011;
    localparam logic [5:0] op_beq  = 6'b000100;
    localparam logic [5:0] op_bne  = 6'b000101;
    localparam logic [5:0] op_addi = 6'b001000;
    localparam logic [5:0] op_andi = 6'b001100;
    localparam logic [5:0] op_ori  = 6'b001101;
    localparam logic [5:0] op_j    = 6'b000010;
    localparam logic [2:0] aluop_add   = 3'b000;
    localparam logic [2:0] aluop_sub   = 3'b001;
    localparam logic [2:0] aluop_funct = 3'b010;
    localparam logic [2:0] aluop_and   = 3'b011;
    localparam logic [2:0] aluop_or    = 3'b100;
    localparam logic [1:0] srcb_rt    = 2'b00;
    localparam logic [1:0] srcb_four  = 2'b01;
    localparam logic [1:0] srcb_imm   = 2'b10;
    localparam logic [1:0] srcb_immsh = 2'b11;
    localparam logic [1:0] pc_alu    = 2'b00;
    localparam logic [1:0] pc_aluout = 2'b01;
    localparam logic [1:0] pc_jump   = 2'b10;
endpackage

// File: rtl/aludec.sv
// aludec: maps aluop and R-type funct to the ALU control code
module aludec
    import mc_controller_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);
    always_comb begin
        alucont = 3'b010;
        case (aluop)
            aluop_sub: alucont = 3'b110;
            aluop_and: alucont = 3'b000;
            aluop_or:  alucont = 3'b001;
            aluop_funct:
                case (funct)
                    6'b100010: alucont = 3'b110;
                    6'b100100: alucont = 3'b000;
                    6'b100101: alucont = 3'b001;
                    6'b101010: alucont = 3'b111;
                    default:   alucont = 3'b010;
                endcase
            default: alucont = 3'b010;
        endcase
    end
endmodule

// File: rtl/mc_fsm.sv
// mc_fsm: Moore state machine sequencing fetch/decode/execute/memory/writeback
module mc_fsm
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       zeroext,
    output logic [2:0] aluop,
    output logic       instr_done
);
    state_t state, next;
    logic is_mem, is_br, is_imm, is_logic;
    assign is_mem   = op == op_lw || op == op_sw;
    assign is_br    = op == op_beq || op == op_bne;
    assign is_logic = op == op_andi || op == op_ori;
    assign is_imm   = op == op_addi || is_logic;
    always_ff @(posedge clk)
        state <= reset ? s_fetch : next;
    always_comb begin
        next = s_fetch;
        pcen = 1'b0;
        iord = 1'b0;
        irwrite = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regdst = 1'b0;
        regwrite = 1'b0;
        alusrca = 1'b0;
        alusrcb = srcb_rt;
        pcsrc = pc_alu;
        zeroext = 1'b0;
        aluop = aluop_add;
        instr_done = 1'b0;
        case (state)
            s_fetch: begin
                alusrcb = srcb_four;
                irwrite = 1'b1;
                pcen = 1'b1;
                next = s_decode;
            end
            s_decode: begin
                alusrcb = srcb_immsh;
                next = is_mem ? s_memadr : op == op_r ? s_execute : is_br ? s_branch :
                       is_imm ? s_immex : op == op_j ? s_jump : s_fetch;
                instr_done = next == s_fetch;
            end
            s_memadr: begin
                alusrca = 1'b1;
                alusrcb = srcb_imm;
                next = op == op_lw ? s_memrd : s_memwr;
            end
            s_memrd: begin
                iord = 1'b1;
                next = s_memwb;
            end
            s_memwb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                instr_done = 1'b1;
            end
            s_memwr: begin
                iord = 1'b1;
                memwrite = 1'b1;
                instr_done = 1'b1;
            end
            s_execute: begin
                alusrca = 1'b1;
                aluop = aluop_funct;
                next = s_aluwb;
            end
            s_aluwb: begin
                regdst = 1'b1;
                regwrite = 1'b1;
                instr_done = 1'b1;
            end
            s_branch: begin
                alusrca = 1'b1;
                aluop = aluop_sub;
                pcsrc = pc_aluout;
                pcen = op == op_beq ? zero : ~zero;
                instr_done = 1'b1;
            end
            s_immex: begin
                alusrca = 1'b1;
                alusrcb = srcb_imm;
                aluop = op == op_andi ? aluop_and : op == op_ori ? aluop_or : aluop_add;
                zeroext = is_logic;
                next = s_immwb;
            end
            s_immwb: begin
                regwrite = 1'b1;
                zeroext = is_logic;
                instr_done = 1'b1;
            end
            s_jump: begin
                pcsrc = pc_jump;
                pcen = 1'b1;
                instr_done = 1'b1;
            end
            default: next = s_fetch;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit; ties the FSM to aludec and suppresses writes during reset
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       zeroext,
    output logic [2:0] alucont,
    output logic       instr_done
);
    logic [2:0] aluop;
    logic f_pcen, f_irwrite, f_memwrite, f_regwrite, f_done;
    mc_fsm u_fsm (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .pcen(f_pcen), .iord(iord), .irwrite(f_irwrite), .memwrite(f_memwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(f_regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .zeroext(zeroext),
        .aluop(aluop), .instr_done(f_done)
    );
    aludec u_aludec (.aluop(aluop), .funct(funct), .alucont(alucont));
    assign pcen       = f_pcen & ~reset;
    assign irwrite    = f_irwrite & ~reset;
    assign memwrite   = f_memwrite & ~reset;
    assign regwrite   = f_regwrite & ~reset;
    assign instr_done = f_done & ~reset;
endmodule
